// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns EXE/MEM load/store bundles into req/ack memory
// transactions and loads MEM/WB. Optional MEM_TIMEOUT_EN aborts stuck requests.
module mem_stage_ctrl
`ifdef MEM_TIMEOUT_EN
#(
    parameter int TIMEOUT = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wregin,
    input  logic        m2regin,
    input  logic        wmemin,
    input  logic [4:0]  RdRtin,
    input  logic [31:0] aluresultin,
    input  logic [31:0] qbin,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        wregout,
    output logic        m2regout,
    output logic [4:0]  RdRtout,
    output logic [31:0] aluresultout,
    output logic [31:0] mdataout,
    output logic        mem_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic       lat_wreg;
    logic       lat_m2reg;
    logic [4:0] lat_rd;
    logic       access;
    logic       misal;
    logic       tmo_hit;

    assign access = m2regin | wmemin;
    assign misal  = access & (aluresultin[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign tmo_hit = (state == BUSY) & ~mem_ack & (cnt == CW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign stall = ((state == IDLE) & access & ~misal) |
                   ((state == BUSY) & ~mem_ack & ~tmo_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            wregout      <= 1'b0;
            m2regout     <= 1'b0;
            RdRtout      <= '0;
            aluresultout <= '0;
            mdataout     <= '0;
            mem_err      <= 1'b0;
            lat_wreg     <= 1'b0;
            lat_m2reg    <= 1'b0;
            lat_rd       <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!access || misal) begin
                        // Misaligned accesses retire as non-writing bundles.
                        wregout      <= wregin & ~misal;
                        m2regout     <= m2regin & ~misal;
                        RdRtout      <= RdRtin;
                        aluresultout <= aluresultin;
                        mdataout     <= '0;
                        if (misal) mem_err <= 1'b1;
                    end else begin
                        // Store wins when both load and store are flagged.
                        mem_req   <= 1'b1;
                        mem_we    <= wmemin;
                        mem_addr  <= aluresultin;
                        mem_wdata <= qbin;
                        lat_wreg  <= wregin & ~wmemin;
                        lat_m2reg <= m2regin & ~wmemin;
                        lat_rd    <= RdRtin;
                        wregout   <= 1'b0;
                        m2regout  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        cnt       <= '0;
`endif
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack || tmo_hit) begin
                        mem_req      <= 1'b0;
                        wregout      <= lat_wreg & mem_ack;
                        m2regout     <= lat_m2reg & mem_ack;
                        RdRtout      <= lat_rd;
                        aluresultout <= mem_addr;
                        mdataout     <= (mem_ack && lat_m2reg) ? mem_rdata : '0;
                        if (!mem_ack) mem_err <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        wregout  <= 1'b0;
                        m2regout <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        cnt      <= cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios then random traffic, checked
// against a transaction-level model holding at most one outstanding memory op.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst, wregin, m2regin, wmemin, mem_ack;
    logic [4:0]  RdRtin;
    logic [31:0] aluresultin, qbin, mem_rdata;
    logic        mem_req, mem_we, stall, wregout, m2regout, mem_err;
    logic [31:0] mem_addr, mem_wdata, aluresultout, mdataout;
    logic [4:0]  RdRtout;

    always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
    mem_stage_ctrl #(.TIMEOUT(TMO)) dut (
`else
    mem_stage_ctrl dut (
`endif
        .clk(clk), .rst(rst), .wregin(wregin), .m2regin(m2regin), .wmemin(wmemin),
        .RdRtin(RdRtin), .aluresultin(aluresultin), .qbin(qbin),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .wregout(wregout), .m2regout(m2regout), .RdRtout(RdRtout),
        .aluresultout(aluresultout), .mdataout(mdataout), .mem_err(mem_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wreg;
        logic        ld;
        logic [4:0]  rd;
        int          age;
    } op_t;

    op_t         pend[$];
    logic        e_req, e_we, e_wreg, e_m2reg, e_err;
    logic [31:0] e_addr, e_wdata, e_alu, e_mdata;
    logic [4:0]  e_rd;
    bit          bus_ok, wb_ok;

    // One pipeline cycle: drive, check stall, advance model, check registered outputs.
    task automatic cycle(input bit r, input logic wr, input logic ld, input logic st,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] qb,
                         input logic ack, input logic [31:0] rdata);
        bit acc, mis, busy, tmo;
        op_t o;
        rst = r; wregin = wr; m2regin = ld; wmemin = st; RdRtin = rd;
        aluresultin = alu; qbin = qb; mem_ack = ack; mem_rdata = rdata;
        #1;
        acc  = ld | st;
        mis  = acc && (alu % 4 != 0);
        busy = pend.size() != 0;
        tmo  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        if (busy) tmo = !ack && (pend[0].age == TMO - 1);
`endif
        chk("stall", stall, 32'((!busy && acc && !mis) || (busy && !ack && !tmo)));

        if (r) begin
            pend.delete();
            {e_req, e_we, e_wreg, e_m2reg, e_err} = '0;
            {e_addr, e_wdata, e_alu, e_mdata, e_rd} = '0;
            bus_ok = 1; wb_ok = 1;
        end else if (!busy) begin
            if (acc && !mis) begin
                o = '{we: st, addr: alu, wdata: qb, wreg: wr && !st, ld: ld && !st, rd: rd, age: 0};
                pend.push_back(o);
                e_req = 1; e_we = st; e_addr = alu; e_wdata = qb; bus_ok = 1;
                e_wreg = 0; e_m2reg = 0; wb_ok = 0;
            end else begin
                e_wreg = wr && !mis; e_m2reg = ld && !mis;
                e_rd = rd; e_alu = alu; e_mdata = 0; wb_ok = 1;
                if (mis) e_err = 1;
            end
        end else if (ack || tmo) begin
            o = pend.pop_front();
            e_req = 0; bus_ok = 0;
            e_wreg = ack && o.wreg; e_m2reg = ack && o.ld;
            e_rd = o.rd; e_alu = o.addr; e_mdata = (ack && o.ld) ? rdata : 0; wb_ok = 1;
            if (tmo) e_err = 1;
        end else begin
            pend[0].age++;
            e_wreg = 0; e_m2reg = 0; wb_ok = 0;
        end

        @(posedge clk); #1;
        chk("mem_req", mem_req, e_req);
        chk("mem_err", mem_err, e_err);
        chk("wregout", wregout, e_wreg);
        chk("m2regout", m2regout, e_m2reg);
        if (bus_ok) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
        end
        if (wb_ok) begin
            chk("RdRtout", RdRtout, e_rd);
            chk("aluresultout", aluresultout, e_alu);
            chk("mdataout", mdataout, e_mdata);
        end
    endtask

    task automatic nop(input bit r, input logic ack);
        cycle(r, 0, 0, 0, 5'd0, 32'd0, 32'd0, ack, 32'h5555_aaaa);
    endtask

    initial begin
        bit r, wr, ld, st, ack;
        int kind;
        logic [31:0] alu;

        e_err = 0;
        nop(1, 0);
        chk("reset_req", mem_req, 0);
        chk("reset_mdata", mdataout, 0);

        // ALU op passes with one cycle latency
        cycle(0, 1, 0, 0, 5'd5, 32'h1234, 32'd0, 0, 32'd0);
        chk("alu_wreg", wregout, 1);
        chk("alu_res", aluresultout, 32'h1234);

        // Load at 0x40, ack three cycles after the request rises
        cycle(0, 1, 1, 0, 5'd7, 32'h40, 32'd0, 0, 32'd0);
        chk("ld_addr", mem_addr, 32'h40);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 5'd7, 32'h40, 32'd0, 0, 32'd0);
        cycle(0, 1, 1, 0, 5'd7, 32'h40, 32'd0, 1, 32'hDEAD_BEEF);
        chk("ld_mdata", mdataout, 32'hDEAD_BEEF);
        chk("ld_m2reg", m2regout, 1);

        // Store at 0x80, acked immediately
        cycle(0, 1, 0, 1, 5'd3, 32'h80, 32'hCAFE, 0, 32'd0);
        chk("st_we", mem_we, 1);
        chk("st_wdata", mem_wdata, 32'hCAFE);
        cycle(0, 1, 0, 1, 5'd3, 32'h80, 32'hCAFE, 1, 32'h1111);
        chk("st_wreg", wregout, 0);

        // Misaligned load: sticky error, no request
        cycle(0, 1, 1, 0, 5'd9, 32'h42, 32'd0, 0, 32'd0);
        chk("mis_err", mem_err, 1);
        nop(0, 1);
        nop(0, 0);
        chk("mis_sticky", mem_err, 1);
        nop(1, 0);

        // Reset in the middle of a transaction, late ack ignored
        cycle(0, 1, 1, 0, 5'd4, 32'h100, 32'd0, 0, 32'd0);
        cycle(0, 1, 1, 0, 5'd4, 32'h100, 32'd0, 0, 32'd0);
        nop(1, 0);
        nop(0, 0);
        nop(0, 1);
        chk("rst_busy_req", mem_req, 0);

`ifdef MEM_TIMEOUT_EN
        cycle(0, 1, 1, 0, 5'd6, 32'h200, 32'd0, 0, 32'd0);
        for (int i = 0; i < TMO; i++) cycle(0, 1, 1, 0, 5'd6, 32'h200, 32'd0, 0, 32'd0);
        chk("tmo_err", mem_err, 1);
        chk("tmo_req", mem_req, 0);
        nop(1, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 59) == 0);
            kind = $urandom_range(0, 3);
            wr   = $urandom_range(0, 1);
            ld   = (kind == 1) || (kind == 3);
            st   = (kind == 2) || (kind == 3);
            alu  = $urandom;
            if ($urandom_range(0, 4) != 0) alu[1:0] = 2'b00;
            ack  = (pend.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            cycle(r, wr, ld, st, 5'($urandom), alu, $urandom, ack, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
